// File: rtl/tcp_msg_poller_defs.sv
// Shared types and widths for the TCP message poller stages.
package tcp_msg_poller_defs;

    localparam int FLOWID_W            = 8;
    localparam int MAX_FLOW_CNT        = 1 << FLOWID_W;
    localparam int MSG_SRC_X_WIDTH     = 8;
    localparam int MSG_SRC_Y_WIDTH     = 8;
    localparam int MSG_SRC_FBITS_WIDTH = 4;
    localparam int POLLER_PTR_W_DEF    = 16;

    typedef struct packed {
        logic [POLLER_PTR_W_DEF-1:0]    tx_length;
        logic [MSG_SRC_X_WIDTH-1:0]     dst_x;
        logic [MSG_SRC_Y_WIDTH-1:0]     dst_y;
        logic [MSG_SRC_FBITS_WIDTH-1:0] dst_fbits;
    } msg_req_mem_struct;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        DECIDE,
        NOTIF,
        REQUEUE
    } sched_state_e;

endpackage

// File: rtl/tcp_msg_poller_sched_ctrl.sv
// Poller scheduler control FSM: one flowid in flight, 5 cycles best case.
// Each read request drops independently on its rdy; notif/requeue hold until accepted.
module tcp_msg_poller_sched_ctrl
    import tcp_msg_poller_defs::*;
(
    input  logic clk,
    input  logic rst,
    input  logic q_rd_val,
    output logic q_rd_rdy,
    output logic mem_req_val,
    input  logic mem_req_rdy,
    input  logic mem_resp_val,
    output logic ptr_req_val,
    input  logic ptr_req_rdy,
    input  logic ptr_resp_val,
    input  logic satisfied,
    output logic notif_val,
    input  logic notif_rdy,
    output logic clear_val,
    output logic wr_val,
    input  logic wr_rdy,
    output logic cap_flowid,
    output logic cap_mem,
    output logic cap_ptr
);

    sched_state_e state, state_nxt;
    logic mem_issued, ptr_issued, mem_got, ptr_got;
    logic mem_issued_nxt, ptr_issued_nxt, mem_got_nxt, ptr_got_nxt;
    logic in_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_issued <= 1'b0;
            ptr_issued <= 1'b0;
            mem_got    <= 1'b0;
            ptr_got    <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_issued <= mem_issued_nxt;
            ptr_issued <= ptr_issued_nxt;
            mem_got    <= mem_got_nxt;
            ptr_got    <= ptr_got_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        q_rd_rdy       = 1'b0;
        mem_req_val    = 1'b0;
        ptr_req_val    = 1'b0;
        notif_val      = 1'b0;
        clear_val      = 1'b0;
        wr_val         = 1'b0;
        cap_flowid     = 1'b0;
        // Responses are only taken while a read is outstanding, so stale ones after reset are dropped.
        in_rd          = (state == RD_REQ) || (state == RD_RESP);
        cap_mem        = in_rd && mem_resp_val && !mem_got;
        cap_ptr        = in_rd && ptr_resp_val && !ptr_got;
        mem_issued_nxt = mem_issued;
        ptr_issued_nxt = ptr_issued;
        mem_got_nxt    = mem_got || cap_mem;
        ptr_got_nxt    = ptr_got || cap_ptr;

        case (state)
            IDLE: begin
                mem_issued_nxt = 1'b0;
                ptr_issued_nxt = 1'b0;
                mem_got_nxt    = 1'b0;
                ptr_got_nxt    = 1'b0;
                if (q_rd_val) begin
                    q_rd_rdy   = 1'b1;
                    cap_flowid = 1'b1;
                    state_nxt  = RD_REQ;
                end
            end
            RD_REQ: begin
                mem_req_val    = !mem_issued;
                ptr_req_val    = !ptr_issued;
                mem_issued_nxt = mem_issued || (mem_req_val && mem_req_rdy);
                ptr_issued_nxt = ptr_issued || (ptr_req_val && ptr_req_rdy);
                if (mem_issued_nxt && ptr_issued_nxt) begin
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                if (mem_got_nxt && ptr_got_nxt) begin
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                state_nxt = satisfied ? NOTIF : REQUEUE;
            end
            NOTIF: begin
                notif_val = 1'b1;
                if (notif_rdy) begin
                    clear_val = 1'b1;
                    state_nxt = IDLE;
                end
            end
            REQUEUE: begin
                wr_val = 1'b1;
                if (wr_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/tcp_msg_poller_sched.sv
// Poller consumer: pops a flowid, reads request + pointers, notifies or re-enqueues.
// 5 cycles per flowid best case; notif/re-enqueue held stable under backpressure.
module tcp_msg_poller_sched
    import tcp_msg_poller_defs::*;
#(
    parameter int POLLER_PTR_W = POLLER_PTR_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           msg_req_q_rd_val,
    input  logic [FLOWID_W-1:0]            msg_req_q_rd_data,
    output logic                           msg_req_q_rd_rdy,
    output logic                           msg_req_q_wr_req_val,
    output logic [FLOWID_W-1:0]            msg_req_q_wr_req_data,
    input  logic                           msg_req_q_wr_req_rdy,
    output logic                           msg_req_mem_rd_req_val,
    output logic [FLOWID_W-1:0]            msg_req_mem_rd_req_addr,
    input  logic                           msg_req_mem_rd_req_rdy,
    input  logic                           msg_req_mem_rd_resp_val,
    input  msg_req_mem_struct              msg_req_mem_rd_resp_data,
    output logic                           ptr_rd_req_val,
    output logic [FLOWID_W-1:0]            ptr_rd_req_flowid,
    input  logic                           ptr_rd_req_rdy,
    input  logic                           ptr_rd_resp_val,
    input  logic [POLLER_PTR_W:0]          ptr_rd_resp_head,
    input  logic [POLLER_PTR_W:0]          ptr_rd_resp_tail,
    output logic                           active_bitvec_clear_req_val,
    output logic [FLOWID_W-1:0]            active_bitvec_clear_req_flowid,
    output logic                           poller_notif_val,
    output logic [FLOWID_W-1:0]            poller_notif_flowid,
    output logic [POLLER_PTR_W-1:0]        poller_notif_len,
    output logic [MSG_SRC_X_WIDTH-1:0]     poller_notif_dst_x,
    output logic [MSG_SRC_Y_WIDTH-1:0]     poller_notif_dst_y,
    output logic [MSG_SRC_FBITS_WIDTH-1:0] poller_notif_dst_fbits,
    input  logic                           poller_notif_rdy
);

    logic [FLOWID_W-1:0]     flowid_q;
    msg_req_mem_struct       req_q;
    logic [POLLER_PTR_W:0]   head_q, tail_q;
    logic [POLLER_PTR_W:0]   avail;
    logic [POLLER_PTR_W-1:0] tx_len;
    logic                    satisfied;
    logic                    cap_flowid, cap_mem, cap_ptr;

    tcp_msg_poller_sched_ctrl u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .q_rd_val     (msg_req_q_rd_val),
        .q_rd_rdy     (msg_req_q_rd_rdy),
        .mem_req_val  (msg_req_mem_rd_req_val),
        .mem_req_rdy  (msg_req_mem_rd_req_rdy),
        .mem_resp_val (msg_req_mem_rd_resp_val),
        .ptr_req_val  (ptr_rd_req_val),
        .ptr_req_rdy  (ptr_rd_req_rdy),
        .ptr_resp_val (ptr_rd_resp_val),
        .satisfied    (satisfied),
        .notif_val    (poller_notif_val),
        .notif_rdy    (poller_notif_rdy),
        .clear_val    (active_bitvec_clear_req_val),
        .wr_val       (msg_req_q_wr_req_val),
        .wr_rdy       (msg_req_q_wr_req_rdy),
        .cap_flowid   (cap_flowid),
        .cap_mem      (cap_mem),
        .cap_ptr      (cap_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            flowid_q <= '0;
            req_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            if (cap_flowid) flowid_q <= msg_req_q_rd_data;
            if (cap_mem)    req_q    <= msg_req_mem_rd_resp_data;
            if (cap_ptr) begin
                head_q <= ptr_rd_resp_head;
                tail_q <= ptr_rd_resp_tail;
            end
        end
    end

    // The extra wrap bit makes the modular difference exact across pointer wrap.
    assign tx_len    = POLLER_PTR_W'(req_q.tx_length);
    assign avail     = tail_q - head_q;
    assign satisfied = (avail >= {1'b0, tx_len});

    assign msg_req_q_wr_req_data          = flowid_q;
    assign msg_req_mem_rd_req_addr        = flowid_q;
    assign ptr_rd_req_flowid              = flowid_q;
    assign active_bitvec_clear_req_flowid = flowid_q;
    assign poller_notif_flowid            = flowid_q;
    assign poller_notif_len               = tx_len;
    assign poller_notif_dst_x             = req_q.dst_x;
    assign poller_notif_dst_y             = req_q.dst_y;
    assign poller_notif_dst_fbits         = req_q.dst_fbits;

endmodule

// File: tb/tb_tcp_msg_poller_sched.sv
// Bench for tcp_msg_poller_sched: queue/memory/pointer models plus an outcome scoreboard.
module tb_tcp_msg_poller_sched;
    import tcp_msg_poller_defs::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                           q_rd_val, q_rd_rdy;
    logic [FLOWID_W-1:0]            q_rd_data;
    logic                           wr_val, wr_rdy;
    logic [FLOWID_W-1:0]            wr_data;
    logic                           mem_req_val, mem_req_rdy, mem_resp_val;
    logic [FLOWID_W-1:0]            mem_addr;
    msg_req_mem_struct              mem_resp_data;
    logic                           ptr_req_val, ptr_req_rdy, ptr_resp_val;
    logic [FLOWID_W-1:0]            ptr_fid;
    logic [16:0]                    ptr_head, ptr_tail;
    logic                           clr_val;
    logic [FLOWID_W-1:0]            clr_fid;
    logic                           notif_val, notif_rdy;
    logic [FLOWID_W-1:0]            notif_fid;
    logic [15:0]                    notif_len;
    logic [MSG_SRC_X_WIDTH-1:0]     notif_x;
    logic [MSG_SRC_Y_WIDTH-1:0]     notif_y;
    logic [MSG_SRC_FBITS_WIDTH-1:0] notif_fb;

    tcp_msg_poller_sched #(.POLLER_PTR_W(16)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .msg_req_q_rd_val               (q_rd_val),
        .msg_req_q_rd_data              (q_rd_data),
        .msg_req_q_rd_rdy               (q_rd_rdy),
        .msg_req_q_wr_req_val           (wr_val),
        .msg_req_q_wr_req_data          (wr_data),
        .msg_req_q_wr_req_rdy           (wr_rdy),
        .msg_req_mem_rd_req_val         (mem_req_val),
        .msg_req_mem_rd_req_addr        (mem_addr),
        .msg_req_mem_rd_req_rdy         (mem_req_rdy),
        .msg_req_mem_rd_resp_val        (mem_resp_val),
        .msg_req_mem_rd_resp_data       (mem_resp_data),
        .ptr_rd_req_val                 (ptr_req_val),
        .ptr_rd_req_flowid              (ptr_fid),
        .ptr_rd_req_rdy                 (ptr_req_rdy),
        .ptr_rd_resp_val                (ptr_resp_val),
        .ptr_rd_resp_head               (ptr_head),
        .ptr_rd_resp_tail               (ptr_tail),
        .active_bitvec_clear_req_val    (clr_val),
        .active_bitvec_clear_req_flowid (clr_fid),
        .poller_notif_val               (notif_val),
        .poller_notif_flowid            (notif_fid),
        .poller_notif_len               (notif_len),
        .poller_notif_dst_x             (notif_x),
        .poller_notif_dst_y             (notif_y),
        .poller_notif_dst_fbits         (notif_fb),
        .poller_notif_rdy               (notif_rdy)
    );

    typedef struct {
        logic [7:0]  fid;
        logic [15:0] len;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  fb;
        logic [16:0] head;
        logic [16:0] tail;
        bit          push;
        int          mlat, plat, mrdy, prdy, nbp, wbp;
        bit          exp_notif;
    } vec_t;

    typedef struct {
        bit          notif;
        logic [7:0]  fid;
        logic [15:0] len;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  fb;
    } exp_t;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]        q_m[$];
    exp_t              sb[$];
    bit                q_gate = 1'b0;
    msg_req_mem_struct mem_tbl [MAX_FLOW_CNT];
    logic [16:0]       ph_tbl  [MAX_FLOW_CNT];
    logic [16:0]       pt_tbl  [MAX_FLOW_CNT];

    int mlat_k = 0, plat_k = 0, mrdy_k = 0, prdy_k = 0, nbp_k = 0, wbp_k = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Environment model: drive after the falling edge, settle, then record
    // the handshakes the next rising edge will take.
    bit          mem_pend = 0, ptr_pend = 0;
    int          mem_cnt = 0, ptr_cnt = 0, mem_wait = 0, ptr_wait = 0, n_wait = 0, w_wait = 0;
    logic [7:0]  mem_a, ptr_a, cur_fid;
    bit          n_stall = 0, w_stall = 0;
    logic [43:0] n_snap;
    logic [7:0]  w_snap;

    always begin
        @(negedge clk);
        q_rd_val  = !q_gate && (q_m.size() > 0);
        q_rd_data = (q_m.size() > 0) ? q_m[0] : 8'd0;
        mem_resp_val = 1'b0;
        mem_resp_data = '0;
        if (mem_pend && mem_cnt == 0) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = mem_tbl[mem_a];
            mem_pend      = 0;
        end else if (mem_pend) mem_cnt--;
        ptr_resp_val = 1'b0;
        ptr_head = '0;
        ptr_tail = '0;
        if (ptr_pend && ptr_cnt == 0) begin
            ptr_resp_val = 1'b1;
            ptr_head     = ph_tbl[ptr_a];
            ptr_tail     = pt_tbl[ptr_a];
            ptr_pend     = 0;
        end else if (ptr_pend) ptr_cnt--;
        mem_req_rdy = (mem_wait == 0);
        ptr_req_rdy = (ptr_wait == 0);
        notif_rdy   = (n_wait == 0);
        wr_rdy      = (w_wait == 0);
        #1;
        if (rst) begin
            mem_wait = 0; ptr_wait = 0; n_wait = 0; w_wait = 0;
            n_stall = 0; w_stall = 0;
        end else begin
            if (q_rd_rdy || wr_val)
                chk("pop_vs_requeue_exclusive", 64'(q_rd_rdy && wr_val), 64'd0);
            if (q_rd_val && q_rd_rdy) begin
                cur_fid  = q_m.pop_front();
                mem_wait = mrdy_k; ptr_wait = prdy_k; n_wait = nbp_k; w_wait = wbp_k;
            end
            if (mem_req_val && mem_req_rdy) begin
                chk("mem_rd_addr", 64'(mem_addr), 64'(cur_fid));
                mem_pend = 1; mem_cnt = mlat_k; mem_a = mem_addr;
            end else if (mem_req_val) mem_wait--;
            if (ptr_req_val && ptr_req_rdy) begin
                chk("ptr_rd_flowid", 64'(ptr_fid), 64'(cur_fid));
                ptr_pend = 1; ptr_cnt = plat_k; ptr_a = ptr_fid;
            end else if (ptr_req_val) ptr_wait--;

            if (n_stall)
                chk("notif_held", {19'd0, notif_val, notif_fid, notif_len, notif_x, notif_y, notif_fb},
                    {19'd0, 1'b1, n_snap});
            if (notif_val && notif_rdy) begin
                if (sb.size() == 0) chk("notif_unexpected", 64'(notif_fid), 64'hFFFF);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("outcome_is_notif", 64'(1), 64'(e.notif));
                    chk("notif_fields", {20'd0, notif_fid, notif_len, notif_x, notif_y, notif_fb},
                        {20'd0, e.fid, e.len, e.x, e.y, e.fb});
                end
            end else if (notif_val) n_wait--;
            if (clr_val || notif_val)
                chk("clear_pulse", {55'd0, clr_val, clr_fid},
                    {55'd0, notif_val && notif_rdy, (notif_val && notif_rdy) ? notif_fid : clr_fid});
            n_stall = notif_val && !notif_rdy;
            n_snap  = {notif_fid, notif_len, notif_x, notif_y, notif_fb};

            if (w_stall) chk("requeue_held", {55'd0, wr_val, wr_data}, {55'd0, 1'b1, w_snap});
            if (wr_val && wr_rdy) begin
                if (sb.size() == 0) chk("requeue_unexpected", 64'(wr_data), 64'hFFFF);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("outcome_is_requeue", 64'(0), 64'(e.notif));
                    chk("requeue_flowid", 64'(wr_data), 64'(e.fid));
                end
                q_m.push_back(wr_data);
                q_gate = 1;
            end else if (wr_val) w_wait--;
            w_stall = wr_val && !wr_rdy;
            w_snap  = wr_data;
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_vals"}, 64'({q_rd_rdy, wr_val, mem_req_val, ptr_req_val, clr_val, notif_val}), 64'd0);
        chk({tag, "_data_lo"}, {wr_data, mem_addr, ptr_fid, clr_fid, notif_fid, notif_len, 8'd0}, 64'd0);
        chk({tag, "_data_hi"}, 64'({notif_x, notif_y, notif_fb}), 64'd0);
        chk({tag, "_state"}, 64'(dut.u_ctrl.state), 64'(IDLE));
    endtask

    task automatic apply_vec(input vec_t v);
        exp_t e;
        @(posedge clk);
        #2;
        mem_tbl[v.fid] = '{v.len, v.x, v.y, v.fb};
        ph_tbl[v.fid]  = v.head;
        pt_tbl[v.fid]  = v.tail;
        mlat_k = v.mlat; plat_k = v.plat; mrdy_k = v.mrdy; prdy_k = v.prdy;
        nbp_k = v.nbp; wbp_k = v.wbp;
        e = '{v.exp_notif, v.fid, v.len, v.x, v.y, v.fb};
        sb.push_back(e);
        if (v.push) q_m.push_back(v.fid);
        q_gate = 0;
        for (int c = 0; c < 400 && sb.size() != 0; c++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("outcome_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8'd3,  16'd64,    8'd1, 8'd2, 4'd3, 17'd0,       17'd100,   1'b1, 0, 0, 0, 0, 0, 0, 1'b1};
        vecs[1] = '{8'd5,  16'd64,    8'd4, 8'd5, 4'd6, 17'd10,      17'd40,    1'b1, 4, 0, 0, 0, 0, 0, 1'b0};
        vecs[2] = '{8'd5,  16'd64,    8'd4, 8'd5, 4'd6, 17'd10,      17'd80,    1'b0, 0, 4, 0, 0, 7, 0, 1'b1};
        vecs[3] = '{8'd7,  16'h0020,  8'd9, 8'd8, 4'd7, 17'h1FFF0,   17'h00010, 1'b1, 2, 2, 0, 0, 0, 0, 1'b1};
        vecs[4] = '{8'd7,  16'h0021,  8'd9, 8'd8, 4'd7, 17'h1FFF0,   17'h00010, 1'b1, 0, 0, 2, 3, 0, 7, 1'b0};
        vecs[5] = '{8'd7,  16'h0020,  8'd1, 8'd1, 4'd1, 17'h1FFF0,   17'h00010, 1'b0, 1, 0, 0, 0, 0, 0, 1'b1};
        vecs[6] = '{8'd9,  16'd0,     8'd2, 8'd2, 4'd2, 17'h00055,   17'h00055, 1'b1, 0, 0, 0, 0, 0, 0, 1'b1};
        vecs[7] = '{8'd10, 16'hFFFF,  8'd3, 8'd3, 4'd3, 17'd0,       17'h0FFFF, 1'b1, 0, 3, 0, 0, 2, 0, 1'b1};
        vecs[8] = '{8'd11, 16'd1,     8'd4, 8'd4, 4'd4, 17'd5,       17'd5,     1'b1, 0, 0, 0, 0, 0, 1, 1'b0};
        vecs[9] = '{8'd11, 16'd0,     8'd4, 8'd4, 4'd4, 17'd5,       17'd5,     1'b0, 0, 0, 0, 0, 0, 0, 1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check_reset_state("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

        // Reset while waiting on a slow memory response; the late response must be ignored.
        @(posedge clk);
        #2;
        mem_tbl[12] = '{16'd8, 8'd6, 8'd6, 4'd6};
        ph_tbl[12] = 17'd0;
        pt_tbl[12] = 17'd8;
        mlat_k = 8; plat_k = 1; mrdy_k = 0; prdy_k = 0; nbp_k = 0; wbp_k = 0;
        q_m.push_back(8'd12);
        repeat (5) @(posedge clk);
        chk("pre_reset_in_rd_resp", 64'(dut.u_ctrl.state), 64'(RD_RESP));
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check_reset_state("midop_reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        chk("idle_after_stale_resp", 64'(dut.u_ctrl.state), 64'(IDLE));
        apply_vec('{8'd12, 16'd8, 8'd6, 8'd6, 4'd6, 17'd0, 17'd8, 1'b1, 0, 0, 0, 0, 0, 0, 1'b1});

        chk("queue_drained", 64'(q_m.size()), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
